// File: rtl/compare_operand_loader.sv
// Serial-to-parallel operand loader for the magnitude comparator: shifts in A then B
// (MSB first) and presents both in parallel under a valid/ack handshake.
module compare_operand_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    input  logic             ack,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             valid,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    // Handshake: valid stays high with a/b frozen until a cycle with ack=1; that edge
    // drops valid and returns to IDLE. ack is ignored while valid=0, and a start seen
    // in the same cycle as the accepting ack is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            LOAD_A: begin
                sa_d = {sa_q[WIDTH-2:0], sin};
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = LOAD_B;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            LOAD_B: begin
                sb_d = {sb_q[WIDTH-2:0], sin};
                if (cnt_q == CNT_LAST) begin
                    // The last B bit goes straight to the output so a/b update together.
                    cnt_d   = '0;
                    a_d     = sa_q;
                    b_d     = {sb_q[WIDTH-2:0], sin};
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign a         = a_q;
    assign b         = b_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_compare_operand_loader.sv
// Bench for compare_operand_loader: a bit-queue model of the load, compared against the
// DUT on every falling clock edge, plus literal pins and randomized traffic.
module tb_compare_operand_loader;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sin;
  logic         ack;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         valid;
  logic         busy;
  logic [1:0]   state_dbg;

  compare_operand_loader #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sin       (sin),
    .ack       (ack),
    .a         (a),
    .b         (b),
    .valid     (valid),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic           m_loading;
  int             m_bits;
  logic [2*W-1:0] m_sh;
  logic [W-1:0]   m_a;
  logic [W-1:0]   m_b;
  logic           m_valid;
  logic [2*W-1:0] exp_q[$];

  logic           chk_en;
  logic           pin_en;
  logic [W-1:0]   pin_a;
  logic [W-1:0]   pin_b;
  logic           pin_valid;
  logic           pin_busy;
  logic           gap_en;
  event           chk_ev;

  int checks;
  int failures;

  task automatic model_reset();
    m_loading = 1'b0;
    m_bits    = 0;
    m_sh      = '0;
    m_a       = '0;
    m_b       = '0;
    m_valid   = 1'b0;
  endtask

  // One clock edge of the operand loader, described as "collect 2*W bits after start".
  task automatic model_update();
    if (m_valid) begin
      if (ack) m_valid = 1'b0;
    end else if (m_loading) begin
      m_sh   = {m_sh[2*W-2:0], sin};
      m_bits = m_bits + 1;
      if (m_bits == 2 * W) begin
        m_a       = m_sh[2*W-1:W];
        m_b       = m_sh[W-1:0];
        m_valid   = 1'b1;
        m_loading = 1'b0;
        exp_q.push_back(m_sh);
      end
    end else if (start) begin
      m_loading = 1'b1;
      m_bits    = 0;
      m_sh      = '0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic s, input logic d, input logic k);
    @(negedge clk);
    #1;
    start = s;
    sin   = d;
    ack   = k;
    @(posedge clk);
    model_update();
    pin_en = 1'b0;
  endtask

  task automatic pin(input logic [W-1:0] pa, input logic [W-1:0] pb,
                     input logic pv, input logic pbsy);
    pin_a     = pa;
    pin_b     = pb;
    pin_valid = pv;
    pin_busy  = pbsy;
    pin_en    = 1'b1;
  endtask

  task automatic load(input logic [W-1:0] va, input logic [W-1:0] vb);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) step(1'b0, va[W-1-i], 1'b0);
    for (int i = 0; i < W; i++) step(1'b0, vb[W-1-i], 1'b0);
  endtask

  // ---------------- scoreboard / compare ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  logic valid_prev;
  int   cyc;
  int   last_rise;

  initial begin
    checks     = 0;
    failures   = 0;
    valid_prev = 1'b0;
    cyc        = 0;
    last_rise  = -1;
  end

  always begin
    @(negedge clk or chk_ev);
    cyc++;
    if (chk_en) begin
      chk("a", a, m_a);
      chk("b", b, m_b);
      chk("valid", W'(valid), W'(m_valid));
      chk("busy", W'(busy), W'(m_loading));
      if (pin_en) begin
        chk("pin_a", a, pin_a);
        chk("pin_b", b, pin_b);
        chk("pin_valid", W'(valid), W'(pin_valid));
        chk("pin_busy", W'(busy), W'(pin_busy));
        chk("pin_model_a", m_a, pin_a);
        chk("pin_model_b", m_b, pin_b);
      end
      if (valid && !valid_prev) begin
        if (exp_q.size() == 0) begin
          chk("pair_unexpected", W'(1), W'(0));
        end else begin
          logic [2*W-1:0] e;
          e = exp_q.pop_front();
          chk("pair_a", a, e[2*W-1:W]);
          chk("pair_b", b, e[W-1:0]);
        end
        if (gap_en) chk("completion_gap", W'(cyc - last_rise), W'(18));
        last_rise = cyc;
      end
    end
    valid_prev = valid;
  end

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    sin    = 1'b0;
    ack    = 1'b0;
    pin_en = 1'b0;
    gap_en = 1'b0;
    pin_a = '0; pin_b = '0; pin_valid = 1'b0; pin_busy = 1'b0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    pin('0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    pin_en = 1'b0;

    // ack while idle does nothing
    step(1'b0, 1'b1, 1'b1);
    pin('0, '0, 1'b0, 1'b0);

    // basic load, ack, second load
    load(8'h0F, 8'h00);
    pin(8'h0F, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    pin(8'h0F, 8'h00, 1'b0, 1'b0);
    load(8'h00, 8'h0F);
    pin(8'h00, 8'h0F, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // equal operands, valid held without ack
    load(8'h0F, 8'h0F);
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    pin(8'h0F, 8'h0F, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // start pulses while busy and in hold; start+ack together
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      logic [W-1:0] va;
      va = 8'hC3;
      step(i == 3, va[W-1-i], 1'b0);
      if (i == 3) pin(8'h0F, 8'h0F, 1'b0, 1'b1);
    end
    for (int i = 0; i < W; i++) begin
      logic [W-1:0] vb;
      vb = 8'h3C;
      step(1'b0, vb[W-1-i], 1'b0);
    end
    pin(8'hC3, 8'h3C, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    pin(8'hC3, 8'h3C, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    pin(8'hC3, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    pin(8'hC3, 8'h3C, 1'b0, 1'b0);

    // asynchronous reset in the middle of operand B
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    #2;
    start = 1'b0;
    rst   = 1'b1;
    model_reset();
    pin('0, '0, 1'b0, 1'b0);
    #1;
    ->chk_ev;
    #1;
    pin_en = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
    load(8'hA5, 8'h5A);
    pin(8'hA5, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // back-to-back loads, ack as soon as valid is seen
    load(8'h81, 8'h7E);
    step(1'b0, 1'b0, 1'b1);
    gap_en = 1'b1;
    load(8'h24, 8'hE7);
    pin(8'h24, 8'hE7, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    gap_en = 1'b0;

    // random full loads with random ack latency
    for (int t = 0; t < 12; t++) begin
      load(W'($urandom), W'($urandom));
      for (int d = $urandom_range(0, 3); d > 0; d--) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);
    end

    // free-running random traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/compare_operand_loader.md
Name: compare_operand_loader

Overview:
Serial-to-parallel operand front end for the 8-bit magnitude comparator. It shifts in two WIDTH-bit operands from a single serial line, MSB first: operand A, then operand B. It then presents both operands in parallel, stable, with a valid/ack handshake. Its a/b outputs drive the comparator's a/b inputs directly. Output registers change only at load completion, so the comparator never sees partially shifted operands.

Parameters:
WIDTH, 8, operand width in bits; the counter is sized to hold WIDTH-1.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a load; sampled only in IDLE
sin  input  1  serial data, MSB first; A bits first, then B bits
ack  input  1  consumer acknowledge; sampled only while valid=1
a  output  WIDTH  operand A to comparator; registered
b  output  WIDTH  operand B to comparator; registered
valid  output  1  a/b hold a freshly completed operand pair
busy  output  1  high while shifting (LOAD_A or LOAD_B)

Behaviour:
- Clock, reset and outputs:
  - One clock domain (clk).
  - rst is asynchronous and active-high.
  - On rst: state=IDLE, a=0, b=0, valid=0, busy=0, bit counter=0, shift registers sa/sb=0.
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- State machine:
  - IDLE
    - start=1 → LOAD_A, cnt=0, busy=1 from the next cycle.
    - sin is ignored during the start cycle.
  - LOAD_A
    - Each edge: sa <= {sa[WIDTH-2:0], sin}, cnt++.
    - On the edge where cnt==WIDTH-1: cnt=0 → LOAD_B.
  - LOAD_B
    - Each edge: sb <= {sb[WIDTH-2:0], sin}, cnt++.
    - On the edge where cnt==WIDTH-1: a <= sa, b <= {sb[WIDTH-2:0], sin}, valid=1, busy=0 → HOLD.
  - HOLD
    - valid=1; a and b are frozen.
    - ack=1 → valid=0 → IDLE on that edge.
    - a and b keep their values until the next load completes; they are never cleared except by rst.
- Timing:
  - If start is captured at edge k, A bits are sampled at edges k+1..k+WIDTH and B bits at edges k+WIDTH+1..k+2*WIDTH.
  - valid rises after edge k+2*WIDTH: 16 cycles for WIDTH=8.
  - The earliest next start is accepted the cycle after ack is accepted. Minimum period is 2*WIDTH+2 cycles.
- Boundary and simultaneous events:
  - start while busy or in HOLD: ignored; no restart, no effect on the counter.
  - start and ack both high in HOLD: ack is accepted → IDLE; start is ignored and must be reasserted.
  - ack while valid=0: ignored.
  - Counter wrap: the counter never exceeds WIDTH-1; it is reset to 0 at each phase change.
  - rst mid-load or in HOLD: the partial operand is discarded and all outputs clear immediately, without waiting for clk.
  - sin X or Z during IDLE or HOLD: no effect on outputs.

Test Plan:
1. After rst, pulse start, then shift 0000_1111 followed by 0000_0000 → at start edge +16: valid=1, a=8'h0F, b=8'h00, busy=0. Comparator output is consistent with a>b.
2. ack one cycle after valid → valid=0 next edge, a/b still 8'h0F/8'h00. New load 0000_0000 / 0000_1111 → a=8'h00, b=8'h0F, valid=1 at +16.
3. Equal operands 0000_1111 / 0000_1111 → a=b=8'h0F, valid=1. Hold valid for 5 cycles without ack → a, b and valid stay unchanged.
4. Pulse start again at bit 3 of A (busy=1) and again during HOLD → no restart, final a/b correct. In HOLD, start+ack in the same cycle → IDLE with valid=0 and no load begun.
5. Assert rst asynchronously between clock edges at bit 5 of B → a=0, b=0, valid=0, busy=0 immediately. A subsequent full load 1010_0101 / 0101_1010 → a=8'hA5, b=8'h5A.
6. Back-to-back loads with ack asserted as soon as valid is seen → two consecutive completions 18 cycles apart, each delivering the correct operand pair.
